// File: rtl/bcd_calendar_counter_pkg.sv
// Shared calendar definitions: BCD month and month-length constants, the default reset date,
// and small BCD helpers (pair divisibility by four, month length, digit increment).
// Latency: n/a (package). Backpressure: n/a.
package bcd_calendar_counter_pkg;

    // BCD month numbers that affect month length or wrap behaviour
    localparam logic [7:0] MON_JAN = 8'h01;
    localparam logic [7:0] MON_FEB = 8'h02;
    localparam logic [7:0] MON_APR = 8'h04;
    localparam logic [7:0] MON_JUN = 8'h06;
    localparam logic [7:0] MON_SEP = 8'h09;
    localparam logic [7:0] MON_NOV = 8'h11;
    localparam logic [7:0] MON_DEC = 8'h12;

    // BCD month lengths
    localparam logic [7:0] LEN_28 = 8'h28;
    localparam logic [7:0] LEN_29 = 8'h29;
    localparam logic [7:0] LEN_30 = 8'h30;
    localparam logic [7:0] LEN_31 = 8'h31;

    // Default reset date 01/01/2000
    localparam logic [7:0]  DEF_DAY   = 8'h01;
    localparam logic [7:0]  DEF_MONTH = 8'h01;
    localparam logic [15:0] DEF_YEAR  = 16'h2000;

    // A two-digit BCD number is divisible by 4 iff:
    // even tens with ones in {0,4,8}, or odd tens with ones in {2,6}.
    function automatic logic div4_pair(input logic [7:0] p);
        logic [3:0] ones;
        ones = p[3:0];
        if (p[4] == 1'b0)
            return (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
        else
            return (ones == 4'd2) || (ones == 4'd6);
    endfunction

    // Length of BCD month m; anything not listed as short is 31 days.
    function automatic logic [7:0] month_len(input logic [7:0] m, input logic lp);
        logic [7:0] len;
        case (m)
            MON_FEB:                            len = lp ? LEN_29 : LEN_28;
            MON_APR, MON_JUN, MON_SEP, MON_NOV: len = LEN_30;
            default:                            len = LEN_31;
        endcase
        return len;
    endfunction

    // Two-digit BCD increment (caller guarantees no overflow past 99).
    function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Four-digit BCD increment; the final carry is dropped so 9999 wraps to 0000.
    function automatic logic [15:0] bcd_inc4(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic nib_ok(input logic [3:0] n);
        return n <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_calendar_counter_if.sv
// Calendar bus: tick/load requests with load date in, current date, flags and pulses out.
// Latency: n/a (wiring only). Backpressure: none, every request is taken the cycle it is seen.
// master = request side (drives tick/load), slave = the calendar counter.
interface bcd_calendar_counter_if;
    logic        tick;
    logic        load;
    logic [7:0]  load_day;
    logic [7:0]  load_month;
    logic [15:0] load_year;
    logic [7:0]  day_bcd;
    logic [7:0]  month_bcd;
    logic [15:0] year_bcd;
    logic        day_tens_blank;
    logic        month_tens_blank;
    logic        leap;
    logic        month_wrap;
    logic        year_wrap;
    logic        load_err;

    modport master (
        output tick, load, load_day, load_month, load_year,
        input  day_bcd, month_bcd, year_bcd, day_tens_blank, month_tens_blank,
               leap, month_wrap, year_wrap, load_err
    );

    modport slave (
        input  tick, load, load_day, load_month, load_year,
        output day_bcd, month_bcd, year_bcd, day_tens_blank, month_tens_blank,
               leap, month_wrap, year_wrap, load_err
    );
endinterface

// File: rtl/bcd_calendar_counter_leap.sv
// Gregorian leap-year detect on a 4-digit BCD year, no binary conversion.
// Latency: combinational. Backpressure: n/a.
// Ports: year_bcd (16-bit BCD year) in, leap out.
module bcd_leap_year_detect
    import bcd_calendar_counter_pkg::*;
(
    input  logic [15:0] year_bcd,
    output logic        leap
);
    // YY != 00: year is not a century, so leap iff YY divisible by 4.
    // YY == 00: century, leap iff divisible by 400, i.e. iff CC divisible by 4.
    always_comb begin
        if (year_bcd[7:0] != 8'h00)
            leap = div4_pair(year_bcd[7:0]);
        else
            leap = div4_pair(year_bcd[15:8]);
    end
endmodule

// File: rtl/bcd_calendar_counter.sv
// BCD calendar date register (DD/MM/YYYY), advances one day per tick, validated load.
// Latency: date/pulses update on the edge where tick/load is sampled, visible next cycle.
// Backpressure: none; reset > load > tick, a tick coincident with load is dropped.
// Ports: clk, reset (sync, active-high), cal (slave modport: tick/load/load_* in;
//        date, tens-blank flags, leap, month_wrap/year_wrap/load_err pulses out).
module bcd_calendar_counter
    import bcd_calendar_counter_pkg::*;
#(
    parameter logic [7:0]  RESET_DAY   = DEF_DAY,
    parameter logic [7:0]  RESET_MONTH = DEF_MONTH,
    parameter logic [15:0] RESET_YEAR  = DEF_YEAR
) (
    input  logic                      clk,
    input  logic                      reset,
    bcd_calendar_counter_if.slave     cal
);

    logic [7:0]  day_q, day_d;
    logic [7:0]  month_q, month_d;
    logic [15:0] year_q, year_d;
    logic        month_wrap_q, month_wrap_d;
    logic        year_wrap_q, year_wrap_d;
    logic        load_err_q, load_err_d;

    logic        cur_leap;
    logic        load_leap;
    logic        load_ok;

    bcd_leap_year_detect u_leap_cur (
        .year_bcd (year_q),
        .leap     (cur_leap)
    );

    bcd_leap_year_detect u_leap_load (
        .year_bcd (cal.load_year),
        .leap     (load_leap)
    );

    // Once every nibble is a decimal digit, BCD ordering equals binary ordering,
    // so the range checks can compare the packed values directly.
    always_comb begin
        logic digits_ok;
        logic month_ok;
        logic day_ok;
        digits_ok = nib_ok(cal.load_day[7:4])   && nib_ok(cal.load_day[3:0])   &&
                    nib_ok(cal.load_month[7:4]) && nib_ok(cal.load_month[3:0]) &&
                    nib_ok(cal.load_year[15:12]) && nib_ok(cal.load_year[11:8]) &&
                    nib_ok(cal.load_year[7:4])  && nib_ok(cal.load_year[3:0]);
        month_ok  = (cal.load_month >= MON_JAN) && (cal.load_month <= MON_DEC);
        day_ok    = (cal.load_day != 8'h00) &&
                    (cal.load_day <= month_len(cal.load_month, load_leap));
        load_ok   = digits_ok && month_ok && day_ok;
    end

    always_comb begin
        day_d        = day_q;
        month_d      = month_q;
        year_d       = year_q;
        month_wrap_d = 1'b0;
        year_wrap_d  = 1'b0;
        load_err_d   = 1'b0;

        if (cal.load) begin
            if (load_ok) begin
                day_d   = cal.load_day;
                month_d = cal.load_month;
                year_d  = cal.load_year;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (cal.tick) begin
            if (day_q == month_len(month_q, cur_leap)) begin
                day_d        = 8'h01;
                month_wrap_d = 1'b1;
                if (month_q == MON_DEC) begin
                    month_d     = MON_JAN;
                    year_d      = bcd_inc4(year_q);
                    year_wrap_d = 1'b1;
                end else begin
                    month_d = bcd_inc2(month_q);
                end
            end else begin
                day_d = bcd_inc2(day_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            day_q        <= RESET_DAY;
            month_q      <= RESET_MONTH;
            year_q       <= RESET_YEAR;
            month_wrap_q <= 1'b0;
            year_wrap_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            day_q        <= day_d;
            month_q      <= month_d;
            year_q       <= year_d;
            month_wrap_q <= month_wrap_d;
            year_wrap_q  <= year_wrap_d;
            load_err_q   <= load_err_d;
        end
    end

    // Flags are decoded straight from the date registers, so they track the visible date.
    assign cal.day_bcd          = day_q;
    assign cal.month_bcd        = month_q;
    assign cal.year_bcd         = year_q;
    assign cal.day_tens_blank   = (day_q[7:4] == 4'd0);
    assign cal.month_tens_blank = (month_q[7:4] == 4'd0);
    assign cal.leap             = cur_leap;
    assign cal.month_wrap       = month_wrap_q;
    assign cal.year_wrap        = year_wrap_q;
    assign cal.load_err         = load_err_q;

endmodule

// File: tb/tb_bcd_calendar_counter.sv
module tb_bcd_calendar_counter;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    bcd_calendar_counter_if cal ();

    bcd_calendar_counter dut (
        .clk   (clk),
        .reset (reset),
        .cal   (cal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ld_d;
        logic [7:0]  ld_m;
        logic [15:0] ld_y;
        logic        tk;
        logic [7:0]  e_d;
        logic [7:0]  e_m;
        logic [15:0] e_y;
        logic        e_leap;
        logic        e_mw;
        logic        e_yw;
        logic        e_err;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit after the rising edge.
    task automatic cycle(input logic rst, input logic ld, input logic tk,
                         input logic [7:0] d, input logic [7:0] m, input logic [15:0] y);
        @(negedge clk);
        reset          = rst;
        cal.load       = ld;
        cal.tick       = tk;
        cal.load_day   = d;
        cal.load_month = m;
        cal.load_year  = y;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        cal.load = 1'b0;
        cal.tick = 1'b0;
    endtask

    task automatic chk_date(input string tag, input logic [7:0] d, input logic [7:0] m,
                            input logic [15:0] y);
        chk({tag, ".day"},   {24'd0, cal.day_bcd},   {24'd0, d});
        chk({tag, ".month"}, {24'd0, cal.month_bcd}, {24'd0, m});
        chk({tag, ".year"},  {16'd0, cal.year_bcd},  {16'd0, y});
    endtask

    task automatic chk_flags(input string tag, input logic lp, input logic mw,
                             input logic yw, input logic er, input logic db, input logic mb);
        chk({tag, ".leap"},   {31'd0, cal.leap},             {31'd0, lp});
        chk({tag, ".mwrap"},  {31'd0, cal.month_wrap},       {31'd0, mw});
        chk({tag, ".ywrap"},  {31'd0, cal.year_wrap},        {31'd0, yw});
        chk({tag, ".err"},    {31'd0, cal.load_err},         {31'd0, er});
        chk({tag, ".dblank"}, {31'd0, cal.day_tens_blank},   {31'd0, db});
        chk({tag, ".mblank"}, {31'd0, cal.month_tens_blank}, {31'd0, mb});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        cal.tick = 1'b0;
        cal.load = 1'b0;
        cal.load_day = 8'h00;
        cal.load_month = 8'h00;
        cal.load_year = 16'h0000;

        //           ld_d   ld_m   ld_y      tk    e_d    e_m    e_y      leap mw yw err
        vecs[0]  = '{8'h28, 8'h02, 16'h1900, 1'b1, 8'h01, 8'h03, 16'h1900, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{8'h28, 8'h02, 16'h2000, 1'b1, 8'h29, 8'h02, 16'h2000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{8'h31, 8'h12, 16'h9999, 1'b1, 8'h01, 8'h01, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{8'h09, 8'h10, 16'h2024, 1'b1, 8'h10, 8'h10, 16'h2024, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{8'h30, 8'h02, 16'h2024, 1'b0, 8'h10, 8'h10, 16'h2024, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{8'h15, 8'h13, 16'h2024, 1'b0, 8'h10, 8'h10, 16'h2024, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{8'h1A, 8'h01, 16'h2024, 1'b0, 8'h10, 8'h10, 16'h2024, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{8'h29, 8'h02, 16'h2023, 1'b0, 8'h10, 8'h10, 16'h2024, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{8'h29, 8'h02, 16'h2024, 1'b0, 8'h29, 8'h02, 16'h2024, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{8'h00, 8'h05, 16'h2024, 1'b0, 8'h29, 8'h02, 16'h2024, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{8'h31, 8'h04, 16'h2024, 1'b0, 8'h29, 8'h02, 16'h2024, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{8'h28, 8'h02, 16'h2100, 1'b1, 8'h01, 8'h03, 16'h2100, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{8'h31, 8'h12, 16'h1999, 1'b1, 8'h01, 8'h01, 16'h2000, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{8'h30, 8'h06, 16'h2024, 1'b1, 8'h01, 8'h07, 16'h2024, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{8'h29, 8'h02, 16'h2400, 1'b1, 8'h01, 8'h03, 16'h2400, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{8'h19, 8'h08, 16'h1996, 1'b1, 8'h20, 8'h08, 16'h1996, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000);
        chk_date("reset", 8'h01, 8'h01, 16'h2000);
        chk_flags("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Table: load, check load_err, optionally tick, then check date and flags
        for (int i = 0; i < NV; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            cycle(1'b0, 1'b1, 1'b0, vecs[i].ld_d, vecs[i].ld_m, vecs[i].ld_y);
            chk({tag, ".ld_err"}, {31'd0, cal.load_err}, {31'd0, vecs[i].e_err});
            if (vecs[i].tk)
                cycle(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 16'h0000);
            chk_date(tag, vecs[i].e_d, vecs[i].e_m, vecs[i].e_y);
            chk_flags(tag, vecs[i].e_leap, vecs[i].e_mw, vecs[i].e_yw,
                      vecs[i].tk ? 1'b0 : vecs[i].e_err,
                      vecs[i].e_d[7:4] == 4'd0, vecs[i].e_m[7:4] == 4'd0);
        end

        // Day walk through October 2024: 09/10 -> 31/10 -> 01/11
        cycle(1'b0, 1'b1, 1'b0, 8'h09, 8'h10, 16'h2024);
        chk("walk.blank0", {31'd0, cal.day_tens_blank}, 32'd1);
        for (int d = 10; d <= 31; d++) begin
            logic [7:0] ed;
            ed = {4'(d / 10), 4'(d % 10)};
            cycle(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 16'h0000);
            chk($sformatf("walk.d%0d", d), {24'd0, cal.day_bcd}, {24'd0, ed});
            chk($sformatf("walk.mw%0d", d), {31'd0, cal.month_wrap}, 32'd0);
            chk($sformatf("walk.blank%0d", d), {31'd0, cal.day_tens_blank}, 32'd0);
        end
        cycle(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 16'h0000);
        chk_date("walk.end", 8'h01, 8'h11, 16'h2024);
        chk_flags("walk.end", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        // Pulse must drop after one cycle with nothing happening
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000);
        chk_date("idle", 8'h01, 8'h11, 16'h2024);
        chk("idle.mw", {31'd0, cal.month_wrap}, 32'd0);

        // Year-wrap pulse width
        cycle(1'b0, 1'b1, 1'b0, 8'h31, 8'h12, 16'h2023);
        cycle(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 16'h0000);
        chk_date("yw", 8'h01, 8'h01, 16'h2024);
        chk("yw.pulse", {31'd0, cal.year_wrap}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000);
        chk("yw.drop", {31'd0, cal.year_wrap}, 32'd0);
        chk("yw.mdrop", {31'd0, cal.month_wrap}, 32'd0);

        // load + tick together: load wins, tick dropped
        cycle(1'b0, 1'b1, 1'b1, 8'h05, 8'h05, 16'h2005);
        chk_date("ldtk", 8'h05, 8'h05, 16'h2005);
        chk_flags("ldtk", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // rejected load + tick: date unchanged, tick still dropped
        cycle(1'b0, 1'b1, 1'b1, 8'h32, 8'h01, 16'h2024);
        chk_date("badldtk", 8'h05, 8'h05, 16'h2005);
        chk("badldtk.err", {31'd0, cal.load_err}, 32'd1);
        // err pulse lasts one cycle
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000);
        chk("err.drop", {31'd0, cal.load_err}, 32'd0);

        // reset with a (bad) load and tick: reset date, no error
        cycle(1'b1, 1'b1, 1'b1, 8'h32, 8'h01, 16'h2024);
        chk_date("rstldtk", 8'h01, 8'h01, 16'h2000);
        chk_flags("rstldtk", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // reset with a valid load and tick also lands on reset date
        cycle(1'b1, 1'b1, 1'b1, 8'h15, 8'h07, 16'h2011);
        chk_date("rstld", 8'h01, 8'h01, 16'h2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
